// File: rtl/blk_9cb6f7_if.sv
// Avalon-MM debug-slave bundle between the CPU and the OCI RAM arbiter.
// master: drives address, strobes, write data; slave: returns readdata, waitrequest.
interface blk_9cb6f7_if;
   logic [7:0]  avs_address;
   logic        avs_read;
   logic        avs_write;
   logic [31:0] avs_writedata;
   logic [3:0]  avs_byteenable;
   logic [31:0] avs_readdata;
   logic        avs_waitrequest;

   modport master (
      output avs_address,
      output avs_read,
      output avs_write,
      output avs_writedata,
      output avs_byteenable,
      input  avs_readdata,
      input  avs_waitrequest
   );

   modport slave (
      input  avs_address,
      input  avs_read,
      input  avs_write,
      input  avs_writedata,
      input  avs_byteenable,
      output avs_readdata,
      output avs_waitrequest
   );
endinterface

// File: rtl/blk_9cb6f7.sv
// Arbiter sharing the 256x32 OCI debug RAM between JTAG action pulses and Avalon.
// Ports: clk/reset_n; jdo + take_* pulses, MonDReg/jtag_rd_done/jtag_overrun (JTAG);
// avs (Avalon slave bundle); ram_addr/ram_wren/ram_byteenable/ram_wrdata/ram_rddata (RAM).
module blk_9cb6f7 (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [37:0] jdo,
   input  logic        take_action_ocimem_a,
   input  logic        take_no_action_ocimem_a,
   input  logic        take_action_ocimem_b,
   output logic [31:0] MonDReg,
   output logic        jtag_rd_done,
   output logic        jtag_overrun,
   blk_9cb6f7_if.slave avs,
   output logic [7:0]  ram_addr,
   output logic        ram_wren,
   output logic [3:0]  ram_byteenable,
   output logic [31:0] ram_wrdata,
   input  logic [31:0] ram_rddata
);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RDWAIT,
      RESP
   } state_e;

   localparam logic OWN_AVS  = 1'b0;
   localparam logic OWN_JTAG = 1'b1;

   state_e      state_q, state_d;
   logic        owner_q, owner_d;
   logic        is_wr_q, is_wr_d;
   logic        last_q, last_d;

   logic        pend_vld_q, pend_vld_d;
   logic        pend_wr_q, pend_wr_d;
   logic [7:0]  pend_addr_q, pend_addr_d;
   logic [31:0] pend_data_q, pend_data_d;
   logic [7:0]  jtag_addr_q, jtag_addr_d;
   logic        overrun_q, overrun_d;

   logic [7:0]  ram_addr_q, ram_addr_d;
   logic        ram_wren_q, ram_wren_d;
   logic [3:0]  ram_be_q, ram_be_d;
   logic [31:0] ram_wrdata_q, ram_wrdata_d;
   logic [31:0] mon_q, mon_d;
   logic [31:0] avs_rdata_q, avs_rdata_d;

   logic        avs_req;
   logic        idle;
   logic        gnt_avs;
   logic        gnt_jtag;
   logic        avs_ack;
   logic        any_pulse;
   logic        slot_free;
   logic        unused_jdo;

   assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

   // Round-robin: on contention the side that did not win last time goes.
   assign avs_req  = avs.avs_read | avs.avs_write;
   assign idle     = (state_q == IDLE);
   assign gnt_jtag = idle & pend_vld_q &
                     (~avs_req | (last_q == OWN_AVS));
   assign gnt_avs  = idle & avs_req &
                     (~pend_vld_q | (last_q == OWN_JTAG));

   // The slot empties in its grant cycle, so a pulse then still fits.
   assign any_pulse = take_action_ocimem_a |
                      take_action_ocimem_b |
                      take_no_action_ocimem_a;
   assign slot_free = ~pend_vld_q | gnt_jtag;

   always_comb begin
      pend_vld_d  = pend_vld_q;
      pend_wr_d   = pend_wr_q;
      pend_addr_d = pend_addr_q;
      pend_data_d = pend_data_q;
      jtag_addr_d = jtag_addr_q;
      overrun_d   = overrun_q;

      if (gnt_jtag) begin
         pend_vld_d = 1'b0;
      end

      if (any_pulse & slot_free) begin
         pend_vld_d = 1'b1;
         if (take_action_ocimem_a) begin
            pend_wr_d   = 1'b0;
            pend_addr_d = jdo[25:18];
            jtag_addr_d = jdo[25:18];
         end else if (take_action_ocimem_b) begin
            pend_wr_d   = 1'b1;
            pend_addr_d = jtag_addr_q;
            pend_data_d = jdo[34:3];
            jtag_addr_d = jtag_addr_q + 8'd1;
         end else begin
            pend_wr_d   = 1'b0;
            pend_addr_d = jtag_addr_q;
            jtag_addr_d = jtag_addr_q + 8'd1;
         end
      end

      if (any_pulse & ~slot_free) begin
         overrun_d = 1'b1;
      end
   end

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      is_wr_d      = is_wr_q;
      last_d       = last_q;
      ram_addr_d   = ram_addr_q;
      ram_wren_d   = 1'b0;
      ram_be_d     = ram_be_q;
      ram_wrdata_d = ram_wrdata_q;
      mon_d        = mon_q;
      avs_rdata_d  = avs_rdata_q;

      unique case (state_q)
         IDLE: begin
            if (gnt_jtag) begin
               owner_d      = OWN_JTAG;
               last_d       = OWN_JTAG;
               is_wr_d      = pend_wr_q;
               ram_addr_d   = pend_addr_q;
               ram_be_d     = 4'hF;
               ram_wrdata_d = pend_data_q;
               ram_wren_d   = pend_wr_q;
               state_d      = ACCESS;
            end else if (gnt_avs) begin
               owner_d      = OWN_AVS;
               last_d       = OWN_AVS;
               is_wr_d      = avs.avs_write;
               ram_addr_d   = avs.avs_address;
               ram_be_d     = avs.avs_write ? avs.avs_byteenable : 4'hF;
               ram_wrdata_d = avs.avs_writedata;
               ram_wren_d   = avs.avs_write;
               state_d      = ACCESS;
            end
         end
         ACCESS: begin
            state_d = is_wr_q ? IDLE : RDWAIT;
         end
         RDWAIT: begin
            if (owner_q == OWN_JTAG) begin
               mon_d = ram_rddata;
            end else begin
               avs_rdata_d = ram_rddata;
            end
            state_d = RESP;
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         owner_q      <= OWN_AVS;
         is_wr_q      <= 1'b0;
         last_q       <= OWN_AVS;
         pend_vld_q   <= 1'b0;
         pend_wr_q    <= 1'b0;
         pend_addr_q  <= 8'h00;
         pend_data_q  <= 32'h0;
         jtag_addr_q  <= 8'h00;
         overrun_q    <= 1'b0;
         ram_addr_q   <= 8'h00;
         ram_wren_q   <= 1'b0;
         ram_be_q     <= 4'h0;
         ram_wrdata_q <= 32'h0;
         mon_q        <= 32'h0;
         avs_rdata_q  <= 32'h0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         is_wr_q      <= is_wr_d;
         last_q       <= last_d;
         pend_vld_q   <= pend_vld_d;
         pend_wr_q    <= pend_wr_d;
         pend_addr_q  <= pend_addr_d;
         pend_data_q  <= pend_data_d;
         jtag_addr_q  <= jtag_addr_d;
         overrun_q    <= overrun_d;
         ram_addr_q   <= ram_addr_d;
         ram_wren_q   <= ram_wren_d;
         ram_be_q     <= ram_be_d;
         ram_wrdata_q <= ram_wrdata_d;
         mon_q        <= mon_d;
         avs_rdata_q  <= avs_rdata_d;
      end
   end

   // Acks come straight from state so a reset can never leave one behind.
   assign avs_ack = (owner_q == OWN_AVS) &
                    (((state_q == ACCESS) & is_wr_q) | (state_q == RESP));

   assign avs.avs_waitrequest = avs_req & ~avs_ack;
   assign avs.avs_readdata    = avs_rdata_q;

   assign jtag_rd_done   = (state_q == RESP) & (owner_q == OWN_JTAG);
   assign jtag_overrun   = overrun_q;
   assign MonDReg        = mon_q;
   assign ram_addr       = ram_addr_q;
   assign ram_wren       = ram_wren_q;
   assign ram_byteenable = ram_be_q;
   assign ram_wrdata     = ram_wrdata_q;

endmodule

// File: tb/tb_blk_9cb6f7.sv
// Directed bench for blk_9cb6f7 with a 1-cycle-latency RAM model.
// Inputs change 1ns after posedge; outputs checked 1-2ns after posedge.
module tb_blk_9cb6f7;
   logic        clk = 1'b0;
   logic        reset_n;
   logic [37:0] jdo;
   logic        take_action_ocimem_a;
   logic        take_no_action_ocimem_a;
   logic        take_action_ocimem_b;
   logic [31:0] MonDReg;
   logic        jtag_rd_done;
   logic        jtag_overrun;
   logic [7:0]  ram_addr;
   logic        ram_wren;
   logic [3:0]  ram_byteenable;
   logic [31:0] ram_wrdata;
   logic [31:0] ram_rddata;

   blk_9cb6f7_if avs_bus ();

   blk_9cb6f7 dut (
      .clk                     (clk),
      .reset_n                 (reset_n),
      .jdo                     (jdo),
      .take_action_ocimem_a    (take_action_ocimem_a),
      .take_no_action_ocimem_a (take_no_action_ocimem_a),
      .take_action_ocimem_b    (take_action_ocimem_b),
      .MonDReg                 (MonDReg),
      .jtag_rd_done            (jtag_rd_done),
      .jtag_overrun            (jtag_overrun),
      .avs                     (avs_bus),
      .ram_addr                (ram_addr),
      .ram_wren                (ram_wren),
      .ram_byteenable          (ram_byteenable),
      .ram_wrdata              (ram_wrdata),
      .ram_rddata              (ram_rddata)
   );

   always #5 clk = ~clk;

   // RAM model: word i preloaded with 32'hC0FFEE_<i>.
   logic [31:0] mem [256];
   logic        mem_load = 1'b1;
   int          wr_count = 0;

   always @(posedge clk) begin
      if (mem_load) begin
         for (int i = 0; i < 256; i++) begin
            mem[i] <= {24'hC0FFEE, 8'(i)};
         end
      end else if (ram_wren) begin
         wr_count <= wr_count + 1;
         for (int k = 0; k < 4; k++) begin
            if (ram_byteenable[k]) begin
               mem[ram_addr][8*k +: 8] <= ram_wrdata[8*k +: 8];
            end
         end
      end
      ram_rddata <= mem[ram_addr];
   end

   int checks = 0;
   int errors = 0;

   localparam logic [31:0] DA = 32'h1111AAAA;
   localparam logic [31:0] DB = 32'h2222BBBB;
   localparam logic [31:0] DC = 32'h3333CCCC;
   localparam logic [31:0] DD = 32'h4444DDDD;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chkb(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   // kind: 0 = ocimem_a, 1 = ocimem_b, 2 = no_action_a
   task automatic pulse(input int kind, input logic [37:0] j);
      jdo                     = j;
      take_action_ocimem_a    = (kind == 0);
      take_action_ocimem_b    = (kind == 1);
      take_no_action_ocimem_a = (kind == 2);
   endtask

   task automatic pclr();
      take_action_ocimem_a    = 1'b0;
      take_action_ocimem_b    = 1'b0;
      take_no_action_ocimem_a = 1'b0;
   endtask

   function automatic logic [37:0] jaddr(input logic [7:0] a);
      return {12'b0, a, 18'b0};
   endfunction

   function automatic logic [37:0] jdata(input logic [31:0] d);
      return {3'b0, d, 3'b0};
   endfunction

   task automatic avs_wr(input logic [7:0] a, input logic [31:0] d,
                         input logic [3:0] be);
      avs_bus.avs_address    = a;
      avs_bus.avs_writedata  = d;
      avs_bus.avs_byteenable = be;
      avs_bus.avs_write      = 1'b1;
      #1 chkb("wr_wait_n", avs_bus.avs_waitrequest, 1'b1);
      nxt();
      chkb("wr_wait_n1", avs_bus.avs_waitrequest, 1'b0);
      chkb("wr_wren", ram_wren, 1'b1);
      chk("wr_addr", 32'(ram_addr), 32'(a));
      chk("wr_data", ram_wrdata, d);
      chk("wr_be", 32'(ram_byteenable), 32'(be));
      avs_bus.avs_write = 1'b0;
      nxt();
      chkb("wr_wren_off", ram_wren, 1'b0);
   endtask

   task automatic avs_rd(input logic [7:0] a, input logic [31:0] exp);
      avs_bus.avs_address = a;
      avs_bus.avs_read    = 1'b1;
      #1 chkb("rd_wait_n", avs_bus.avs_waitrequest, 1'b1);
      nxt();
      chkb("rd_wait_n1", avs_bus.avs_waitrequest, 1'b1);
      chk("rd_addr", 32'(ram_addr), 32'(a));
      chkb("rd_wren", ram_wren, 1'b0);
      nxt();
      chkb("rd_wait_n2", avs_bus.avs_waitrequest, 1'b1);
      nxt();
      chkb("rd_wait_n3", avs_bus.avs_waitrequest, 1'b0);
      chk("rd_data", avs_bus.avs_readdata, exp);
      avs_bus.avs_read = 1'b0;
      nxt();
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_addr"}, 32'(ram_addr), 32'h0);
      chkb({tag, "_wren"}, ram_wren, 1'b0);
      chk({tag, "_be"}, 32'(ram_byteenable), 32'h0);
      chk({tag, "_wrdata"}, ram_wrdata, 32'h0);
      chk({tag, "_mon"}, MonDReg, 32'h0);
      chkb({tag, "_rddone"}, jtag_rd_done, 1'b0);
      chkb({tag, "_ovr"}, jtag_overrun, 1'b0);
      chk({tag, "_rdata"}, avs_bus.avs_readdata, 32'h0);
   endtask

   int wr_base;

   initial begin
      reset_n                = 1'b0;
      jdo                    = '0;
      pclr();
      avs_bus.avs_address    = 8'h00;
      avs_bus.avs_read       = 1'b0;
      avs_bus.avs_write      = 1'b0;
      avs_bus.avs_writedata  = 32'h0;
      avs_bus.avs_byteenable = 4'h0;

      // Reset values; waitrequest follows the request during reset
      nxt();
      mem_load = 1'b0;
      chk_zero("rst");
      chkb("rst_wait_idle", avs_bus.avs_waitrequest, 1'b0);
      avs_bus.avs_read = 1'b1;
      #1 chkb("rst_wait_req", avs_bus.avs_waitrequest, 1'b1);
      avs_bus.avs_read = 1'b0;
      nxt();
      reset_n = 1'b1;

      // Avalon write then read back
      avs_wr(8'h10, 32'hDEADBEEF, 4'hF);
      avs_rd(8'h10, 32'hDEADBEEF);

      // JTAG: load FE + read, two writes across the wrap, then read at 00
      pulse(0, jaddr(8'hFE));
      nxt();
      pulse(1, jdata(DA));
      nxt();
      pclr();
      chk("j_rd_addr", 32'(ram_addr), 32'hFE);
      chkb("j_rd_wren", ram_wren, 1'b0);
      nxt();
      chkb("j_rddone_early", jtag_rd_done, 1'b0);
      nxt();
      chkb("j_rddone", jtag_rd_done, 1'b1);
      chk("j_mon_fe", MonDReg, 32'hC0FFEEFE);
      nxt();
      chkb("j_rddone_pulse", jtag_rd_done, 1'b0);
      nxt();
      chkb("j_wa_wren", ram_wren, 1'b1);
      chk("j_wa_addr", 32'(ram_addr), 32'hFE);
      chk("j_wa_data", ram_wrdata, DA);
      chk("j_wa_be", 32'(ram_byteenable), 32'hF);
      pulse(1, jdata(DB));
      nxt();
      pclr();
      nxt();
      chkb("j_wb_wren", ram_wren, 1'b1);
      chk("j_wb_addr", 32'(ram_addr), 32'hFF);
      chk("j_wb_data", ram_wrdata, DB);
      pulse(2, '0);
      nxt();
      pclr();
      chk("mem_fe", mem[8'hFE], DA);
      chk("mem_ff", mem[8'hFF], DB);
      nxt();
      chk("j_wrap_addr", 32'(ram_addr), 32'h00);
      nxt();
      nxt();
      chkb("j_rddone_00", jtag_rd_done, 1'b1);
      chk("j_mon_00", MonDReg, 32'hC0FFEE00);
      chkb("j_no_ovr", jtag_overrun, 1'b0);
      nxt();

      // Fresh reset: simultaneous requests, JTAG wins first
      reset_n = 1'b0;
      nxt();
      reset_n = 1'b1;
      pulse(0, jaddr(8'h20));
      nxt();
      pclr();
      avs_bus.avs_address = 8'h10;
      avs_bus.avs_read    = 1'b1;
      #1 chkb("arb_wait0", avs_bus.avs_waitrequest, 1'b1);
      nxt();
      chk("arb_j_addr", 32'(ram_addr), 32'h20);
      chkb("arb_wait1", avs_bus.avs_waitrequest, 1'b1);
      nxt();
      nxt();
      chkb("arb_rddone", jtag_rd_done, 1'b1);
      chk("arb_mon", MonDReg, 32'hC0FFEE20);
      chkb("arb_wait_resp", avs_bus.avs_waitrequest, 1'b1);
      nxt();
      chkb("arb_wait_g", avs_bus.avs_waitrequest, 1'b1);
      nxt();
      chk("arb_a_addr", 32'(ram_addr), 32'h10);
      nxt();
      chkb("arb_wait_n2", avs_bus.avs_waitrequest, 1'b1);
      nxt();
      chkb("arb_wait_n3", avs_bus.avs_waitrequest, 1'b0);
      chk("arb_rdata", avs_bus.avs_readdata, 32'hDEADBEEF);
      avs_bus.avs_read = 1'b0;
      nxt();

      // Overrun: second ocimem_b dropped during an Avalon read
      wr_base = wr_count;
      avs_bus.avs_address = 8'hFE;
      avs_bus.avs_read    = 1'b1;
      nxt();
      pulse(1, jdata(DC));
      nxt();
      pclr();
      chkb("ovr_pre", jtag_overrun, 1'b0);
      nxt();
      pulse(1, jdata(DD));
      #1 chkb("ovr_rd_wait", avs_bus.avs_waitrequest, 1'b0);
      chk("ovr_rd_data", avs_bus.avs_readdata, DA);
      nxt();
      pclr();
      avs_bus.avs_read = 1'b0;
      chkb("ovr_set", jtag_overrun, 1'b1);
      nxt();
      chkb("ovr_wren", ram_wren, 1'b1);
      chk("ovr_addr", 32'(ram_addr), 32'h20);
      chk("ovr_data", ram_wrdata, DC);
      nxt();
      nxt();
      nxt();
      chk("ovr_mem20", mem[8'h20], DC);
      chk("ovr_mem21", mem[8'h21], 32'hC0FFEE21);
      chk("ovr_wr_cnt", 32'(wr_count - wr_base), 32'd1);
      chkb("ovr_sticky", jtag_overrun, 1'b1);

      // Partial byte-enable write
      avs_wr(8'h30, 32'hFFFFFFFF, 4'hF);
      avs_wr(8'h30, 32'h00001234, 4'b0011);
      avs_rd(8'h30, 32'hFFFF1234);

      // Reset in RDWAIT of an Avalon read, request held through it
      avs_bus.avs_address = 8'h30;
      avs_bus.avs_read    = 1'b1;
      nxt();
      nxt();
      reset_n = 1'b0;
      #1;
      chk_zero("mid");
      chkb("mid_wait", avs_bus.avs_waitrequest, 1'b1);
      nxt();
      chk("mid_rdata_hold", avs_bus.avs_readdata, 32'h0);
      chkb("mid_wait2", avs_bus.avs_waitrequest, 1'b1);
      reset_n = 1'b1;
      #1 chkb("re_wait0", avs_bus.avs_waitrequest, 1'b1);
      nxt();
      chk("re_addr", 32'(ram_addr), 32'h30);
      chkb("re_wait1", avs_bus.avs_waitrequest, 1'b1);
      nxt();
      chkb("re_wait2", avs_bus.avs_waitrequest, 1'b1);
      nxt();
      chkb("re_wait3", avs_bus.avs_waitrequest, 1'b0);
      chk("re_rdata", avs_bus.avs_readdata, 32'hFFFF1234);
      avs_bus.avs_read = 1'b0;
      nxt();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/blk_9cb6f7.md
# qsys_routing_controller_nios2_qsys_0_ocimem_arbiter

Shares the Nios II on-chip debug memory (256 x 32 single-port RAM, 1-cycle read latency) between two requesters: the JTAG debug module's sysclk-side action pulses and the CPU's Avalon-MM debug slave. It holds at most one JTAG command pending, grants the RAM round-robin, and returns read data to either side. It sits between the jtag_debug_module wrapper outputs (jdo, take_action_ocimem_*) and the OCI RAM instance.

## Interface
- No parameters. Depth is fixed at 256 words and width at 32 bits.
- clk  in  1  system clock. All logic is in this one domain.
- reset_n  in  1  asynchronous, active-low reset.
- jdo  in  38  JTAG data-out bus. It is valid in the cycle of any take_* pulse.
- take_action_ocimem_a  in  1  pulse: load the JTAG address from jdo[25:18], then queue a read.
- take_no_action_ocimem_a  in  1  pulse: queue a read at the JTAG address, with post-increment.
- take_action_ocimem_b  in  1  pulse: queue a write of jdo[34:3] at the JTAG address, with post-increment.
- MonDReg  out  32  JTAG read-data register.
- jtag_rd_done  out  1  one-cycle pulse when MonDReg updates.
- jtag_overrun  out  1  sticky flag: a JTAG pulse was dropped.
- avs_address  in  8  Avalon word address.
- avs_read / avs_write  in  1  Avalon request strobes. These are never asserted together.
- avs_writedata  in  32  Avalon write data.
- avs_byteenable  in  4  Avalon byte enables.
- avs_readdata  out  32  Avalon read data. Valid when avs_waitrequest is low during a read.
- avs_waitrequest  out  1  equals (avs_read | avs_write) & ~avs_ack.
- ram_addr  out  8  registered RAM address.
- ram_wren  out  1  registered RAM write strobe.
- ram_byteenable  out  4  registered RAM byte enables.
- ram_wrdata  out  32  registered RAM write data.
- ram_rddata  in  32  RAM read data. Valid 1 cycle after ram_addr.

## Operation
- **Reset values:** all outputs 0, state IDLE, jtag_addr 0, pending empty, last_grant = AVS.
  - avs_waitrequest follows its equation during reset, so it is high whenever a request is present.
- **JTAG pending slot:**
  - A single entry holding {op, addr, data}.
  - A pulse that arrives while the slot is occupied is dropped and sets jtag_overrun. Only reset clears jtag_overrun.
  - The slot frees in its grant cycle, and a pulse arriving in that same cycle is accepted.
  - The three pulses are mutually exclusive. If more than one is asserted in a cycle, precedence is ocimem_a, then ocimem_b, then no_action.
- **JTAG address:**
  - On ocimem_a, jtag_addr <= jdo[25:18]. The read is queued at that new address and does not increment.
  - no_action_a and ocimem_b use the current jtag_addr, then jtag_addr <= jtag_addr + 1 at acceptance.
  - The increment is 8-bit with wrap: 8'hFF becomes 8'h00.
- **Arbitration:** evaluated only in IDLE.
  - If only one requester is valid, it is granted.
  - If both are valid, the requester opposite last_grant is granted.
  - last_grant updates on every grant.
- **FSM states:** IDLE, ACCESS, RDWAIT, RESP.
  - IDLE, grant: register ram_addr, ram_byteenable, ram_wrdata, and ram_wren (1 for writes), then go to ACCESS.
  - ACCESS, write: ram_wren is high for this one cycle. If the owner is Avalon, avs_ack = 1 this cycle. Go to IDLE.
  - ACCESS, read: ram_wren = 0. Go to RDWAIT.
  - RDWAIT: capture ram_rddata into avs_readdata (Avalon owner) or MonDReg (JTAG owner). Go to RESP.
  - RESP: if the owner is Avalon, avs_ack = 1. If the owner is JTAG, jtag_rd_done = 1. Go to IDLE.
- **Write payloads:**
  - JTAG writes always use byteenable 4'hF.
  - Avalon writes pass avs_byteenable through unchanged.
- **Address hold:** ram_addr holds its last value when idle. ram_wren is high only in ACCESS for writes.
- **Reset mid-transaction:** the FSM aborts to IDLE and pending data is lost. No ack is issued.

## Timing
- Latency is measured from the IDLE cycle N in which the request is sampled and granted.
- **Avalon write:** waitrequest is low in N+1, when the RAM write occurs. Occupancy is 2 cycles.
- **Avalon read:** ram_addr at N+1, ram_rddata at N+2, waitrequest low at N+3 with avs_readdata valid. Occupancy is 4 cycles.
- **JTAG write:** RAM written at N+1.
- **JTAG read:** MonDReg updates and jtag_rd_done pulses at N+3.
- **Throughput:** the next grant occurs no earlier than the cycle after return to IDLE.
- **Avalon retention:** an Avalon request held across a JTAG transaction keeps waitrequest high and is served next.

## Test plan
- Avalon write addr 8'h10, data 32'hDEADBEEF, be 4'hF; then read addr 8'h10 -> waitrequest low 1 cycle after the write is granted; the read returns 32'hDEADBEEF with waitrequest low at N+3.
- ocimem_a with jdo[25:18]=8'hFE, then ocimem_b ×2 with data A and B -> RAM[8'hFE]=A, RAM[8'hFF]=B, jtag_addr wraps to 8'h00.
- Avalon read and a JTAG read granted in the same IDLE cycle after reset -> JTAG wins (last_grant=AVS); the Avalon read completes next, 4 cycles later.
- Two ocimem_b pulses 1 cycle apart while an Avalon read is in progress -> the second pulse is dropped, jtag_overrun=1, and only one write occurs.
- Avalon write with be 4'b0011 over 32'hFFFFFFFF, writedata 32'h00001234 -> the readback is 32'hFFFF1234.
- reset_n asserted in RDWAIT of an Avalon read -> all outputs 0 and no ack. After release, the held request restarts and completes normally.
